// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, injector FSM states,
// destination modes and the random-destination helper.
package noc_pkg;

  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 26;
  localparam int PID_MSB  = 15;
  localparam int PID_LSB  = 6;
  localparam int SID_MSB  = 5;
  localparam int SID_LSB  = 0;
  localparam int PID_W    = PID_MSB - PID_LSB + 1;

  localparam bit DEST_FIXED  = 1'b0;
  localparam bit DEST_RANDOM = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    REQ,
    ACK
  } inj_state_t;

  // Never returns the sender's own id: bump x when it collides.
  function automatic logic [5:0] randDest(
    input logic [7:0] lfsr,
    input logic [5:0] self,
    input int         dim
  );
    logic [1:0] m;
    logic [1:0] x;
    logic [1:0] y;
    logic [5:0] d;
    m = 2'(dim - 1);
    x = lfsr[1:0] & m;
    y = lfsr[3:2] & m;
    d = {1'b0, x, 1'b0, y};
    if (d == self) begin
      x = (x + 2'd1) & m;
      d = {1'b0, x, 1'b0, y};
    end
    return d;
  endfunction

endpackage

// File: rtl/traffic_injector_if.sv
// Injector-to-router Local port link: flit, request, grant and full.
interface traffic_injector_if #(
  parameter int dataWidth = 32
);
  logic [dataWidth-1:0] PacketOut;
  logic                 ReqDnStr;
  logic                 GntDnStr;
  logic                 DnStrFull;

  modport master (
    output PacketOut,
    output ReqDnStr,
    input  GntDnStr,
    input  DnStrFull
  );

  modport slave (
    input  PacketOut,
    input  ReqDnStr,
    output GntDnStr,
    output DnStrFull
  );
endinterface

// File: rtl/noc_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4; advances only when step is high.
module noc_lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic fb;
  assign fb = value[7] ^ value[5] ^ value[4] ^ value[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= seed;
    end else if (step) begin
      value <= {value[6:0], fb};
    end
  end

endmodule

// File: rtl/traffic_injector.sv
// Per-PE packet source: paced single-flit packets to the router
// Local port over a Req/Gnt handshake gated by Full.
module traffic_injector
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID       = 6'b000_000,
  parameter logic [5:0] ModuleID       = 6'b000_000,
  parameter int         dataWidth      = 32,
  parameter int         dim            = 4,
  parameter int         InjectInterval = 8,
  parameter int         NumPackets     = 16,
  parameter bit         DestMode       = 1'b0,
  parameter logic [5:0] FixedDest      = 6'b011_011,
  parameter logic [7:0] LfsrSeed       = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  traffic_injector_if.master        bus,
  output logic [15:0]               sent_count,
  output logic                      done
);

  localparam logic [15:0] GAP_LOAD = 16'(InjectInterval);
  localparam logic [15:0] LIMIT    = 16'(NumPackets);
  localparam bit          LIMITED  = (NumPackets != 0);

  inj_state_t           state;
  logic [15:0]          gapCnt;
  logic [PID_W-1:0]     pid;
  logic [7:0]           lfsr;
  logic [5:0]           dest;
  logic [dataWidth-1:0] flit;
  logic                 granted;
  logic                 limitHit;

  assign granted  = (state == REQ) && bus.GntDnStr;
  assign limitHit = LIMITED && (sent_count == LIMIT);

  noc_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (granted),
    .seed  (LfsrSeed),
    .value (lfsr)
  );

  always_comb begin
    dest = FixedDest;
    if (DestMode == DEST_RANDOM) begin
      dest = randDest(lfsr, ModuleID, dim);
    end
  end

  always_comb begin
    flit                   = '0;
    flit[DEST_MSB:DEST_LSB] = dest;
    flit[PID_MSB:PID_LSB]   = pid;
    flit[SID_MSB:SID_LSB]   = ModuleID;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      gapCnt        <= '0;
      pid           <= '0;
      sent_count    <= '0;
      done          <= 1'b0;
      bus.PacketOut <= '0;
      bus.ReqDnStr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && !done) begin
            state  <= GAP;
            gapCnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (!enable) begin
            state <= IDLE;
          end else if (gapCnt != 0) begin
            gapCnt <= gapCnt - 16'd1;
          end else if (!bus.DnStrFull) begin
            bus.PacketOut <= flit;
            bus.ReqDnStr  <= 1'b1;
            state         <= REQ;
          end
        end
        // Full and enable no longer matter once a request is up.
        REQ: begin
          if (bus.GntDnStr) begin
            bus.ReqDnStr <= 1'b0;
            pid          <= pid + 1'b1;
            sent_count   <= sent_count + 16'd1;
            state        <= ACK;
          end
        end
        ACK: begin
          if (limitHit) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state  <= GAP;
            gapCnt <= GAP_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unusedRouter;
  assign unusedRouter = ^routerID;

endmodule

// File: tb/tb_traffic_injector.sv
// Directed bench for traffic_injector: three instances cover
// fixed-dest pacing, packet limit and random destinations.
module tb_traffic_injector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCmp = 0;
  int nErr = 0;

  logic enA = 0, enB = 0, enC = 0;
  logic fullA = 0, autoGntA = 0, manGntA = 0;
  logic autoGntB = 0, autoGntC = 0;
  logic [15:0] sentA, sentB, sentC;
  logic doneA, doneB, doneC;

  traffic_injector_if #(.dataWidth(32)) ifA ();
  traffic_injector_if #(.dataWidth(32)) ifB ();
  traffic_injector_if #(.dataWidth(32)) ifC ();

  assign ifA.GntDnStr  = (autoGntA & ifA.ReqDnStr) | manGntA;
  assign ifA.DnStrFull = fullA;
  assign ifB.GntDnStr  = autoGntB & ifB.ReqDnStr;
  assign ifB.DnStrFull = 1'b0;
  assign ifC.GntDnStr  = autoGntC & ifC.ReqDnStr;
  assign ifC.DnStrFull = 1'b0;

  traffic_injector #(
    .ModuleID(6'b000_000), .InjectInterval(0), .NumPackets(0),
    .DestMode(1'b0), .FixedDest(6'b011_011)
  ) dutA (
    .clk(clk), .reset(reset), .enable(enA), .bus(ifA.master),
    .sent_count(sentA), .done(doneA)
  );

  traffic_injector #(
    .ModuleID(6'b000_001), .InjectInterval(2), .NumPackets(3),
    .DestMode(1'b0), .FixedDest(6'b011_011)
  ) dutB (
    .clk(clk), .reset(reset), .enable(enB), .bus(ifB.master),
    .sent_count(sentB), .done(doneB)
  );

  traffic_injector #(
    .ModuleID(6'b001_010), .InjectInterval(0), .NumPackets(0),
    .DestMode(1'b1), .LfsrSeed(8'hA5)
  ) dutC (
    .clk(clk), .reset(reset), .enable(enC), .bus(ifC.master),
    .sent_count(sentC), .done(doneC)
  );

  typedef struct {
    int          idx;
    logic [31:0] flit;
  } vec_t;

  vec_t t1Vec[3];
  vec_t t4Vec[6];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic reqOf(input int inst);
    case (inst)
      0:       return ifA.ReqDnStr;
      1:       return ifB.ReqDnStr;
      default: return ifC.ReqDnStr;
    endcase
  endfunction

  task automatic waitReq(input int inst, input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      if (reqOf(inst)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      nCmp++;
      nErr++;
      $display("FAIL wait_req inst%0d: got timeout expected ReqDnStr=1", inst);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int last;
    int hi;
    int bad;
    logic [5:0] d;
    logic [31:0] held;

    t1Vec[0] = '{0, 32'h6C00_0000};
    t1Vec[1] = '{1, 32'h6C00_0040};
    t1Vec[2] = '{2, 32'h6C00_0080};
    // Seed A5 walks A5,4A,95,2A,54,A9; A9 maps onto self and is bumped.
    t4Vec[0] = '{0, 32'h2400_000A};
    t4Vec[1] = '{1, 32'h4800_004A};
    t4Vec[2] = '{2, 32'h2400_008A};
    t4Vec[3] = '{3, 32'h4800_00CA};
    t4Vec[4] = '{4, 32'h0400_010A};
    t4Vec[5] = '{5, 32'h4800_014A};

    repeat (3) @(negedge clk);
    check("rst_pkt", ifA.PacketOut, 32'h0);
    check("rst_req", 32'(ifA.ReqDnStr), 32'd0);
    check("rst_sent", 32'(sentA), 32'd0);
    check("rst_done", 32'(doneA), 32'd0);
    reset = 1'b0;

    // T1: fixed destination, back-to-back at one flit per 3 cycles
    enA = 1'b1;
    autoGntA = 1'b1;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      waitReq(0, 20, ok);
      check($sformatf("t1_flit%0d", t1Vec[i].idx), ifA.PacketOut, t1Vec[i].flit);
      if (i > 0) check("t1_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
      if (i == 2) enA = 1'b0;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("t1_sent", 32'(sentA), 32'd3);
    check("t1_req_off", 32'(ifA.ReqDnStr), 32'd0);

    // T2: Full blocks request; stray grant ignored; grant beats Full
    autoGntA = 1'b0;
    fullA = 1'b1;
    manGntA = 1'b1;
    enA = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifA.ReqDnStr) hi++;
    end
    check("t2_full_blocks", 32'(hi), 32'd0);
    check("t2_stray_gnt", 32'(sentA), 32'd3);
    manGntA = 1'b0;
    fullA = 1'b0;
    @(negedge clk);
    check("t2_req_rise", 32'(ifA.ReqDnStr), 32'd1);
    check("t2_flit", ifA.PacketOut, 32'h6C00_00C0);
    held = ifA.PacketOut;
    fullA = 1'b1;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (!ifA.ReqDnStr || ifA.PacketOut !== held) hi++;
    end
    check("t2_req_held", 32'(hi), 32'd0);
    manGntA = 1'b1;
    @(negedge clk);
    manGntA = 1'b0;
    enA = 1'b0;
    check("t2_req_drop", 32'(ifA.ReqDnStr), 32'd0);
    check("t2_sent", 32'(sentA), 32'd4);
    fullA = 1'b0;
    repeat (4) @(negedge clk);

    // T5: reset while a request is pending
    enA = 1'b1;
    waitReq(0, 20, ok);
    reset = 1'b1;
    @(negedge clk);
    check("t5_req", 32'(ifA.ReqDnStr), 32'd0);
    check("t5_pkt", ifA.PacketOut, 32'h0);
    check("t5_sent", 32'(sentA), 32'd0);
    check("t5_done", 32'(doneA), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    waitReq(0, 20, ok);
    check("t5_first_pid0", ifA.PacketOut, 32'h6C00_0000);

    // T6: unlimited run across the PacketID wrap
    autoGntA = 1'b1;
    for (int k = 0; k < 1030; k++) begin
      waitReq(0, 20, ok);
      if (!ok) break;
      if (k == 1023) check("t6_pid1023", 32'(ifA.PacketOut[15:6]), 32'd1023);
      if (k == 1024) check("t6_pid_wrap", 32'(ifA.PacketOut[15:6]), 32'd0);
      if (k == 1029) enA = 1'b0;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("t6_sent", 32'(sentA), 32'd1030);
    check("t6_not_done", 32'(doneA), 32'd0);
    autoGntA = 1'b0;

    // T3: packet limit and sticky done
    autoGntB = 1'b1;
    enB = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sentB == 16'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_reached3", 32'(ok), 32'd1);
    check("t3_done_late", 32'(doneB), 32'd0);
    @(negedge clk);
    check("t3_done", 32'(doneB), 32'd1);
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (ifB.ReqDnStr) hi++;
    end
    check("t3_no_req", 32'(hi), 32'd0);
    check("t3_sent", 32'(sentB), 32'd3);
    check("t3_done_sticky", 32'(doneB), 32'd1);

    // T4: random destinations, in range and never self
    autoGntC = 1'b1;
    enC = 1'b1;
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      waitReq(2, 20, ok);
      if (!ok) break;
      if (k < 6) check($sformatf("t4_flit%0d", t4Vec[k].idx), ifC.PacketOut, t4Vec[k].flit);
      d = ifC.PacketOut[31:26];
      if (d[5] || d[2] || d == 6'b001_010) bad++;
      if (k == 499) enC = 1'b0;
      @(negedge clk);
    end
    check("t4_dest_range", 32'(bad), 32'd0);
    repeat (5) @(negedge clk);
    check("t4_sent", 32'(sentC), 32'd500);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    enC = 1'b1;
    for (int k = 0; k < 6; k++) begin
      waitReq(2, 20, ok);
      if (!ok) break;
      check($sformatf("t4_repeat%0d", t4Vec[k].idx), ifC.PacketOut, t4Vec[k].flit);
      if (k == 5) enC = 1'b0;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
